// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage for the single-cycle core.
// Holds the architectural PC, fetches the word at that PC over a req/ack
// memory handshake, presents it downstream with valid/ready, and loads the
// next PC only when the current instruction retires.
module pc_fetch_unit #(
    parameter int unsigned pc_width    = 32,
    parameter int unsigned instr_width = 32,
    parameter logic [pc_width-1:0] reset_addr = '0,
    parameter int unsigned count_width = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [pc_width-1:0]    next_instr_addr,
    output logic [pc_width-1:0]    read_addr,
    output logic                   imem_req,
    output logic [pc_width-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [instr_width-1:0] imem_rdata,
    output logic [instr_width-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   halt,
    output logic                   halted,
    output logic [count_width-1:0] retired_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [pc_width-1:0]    read_addr_q, read_addr_d;
    logic [instr_width-1:0] instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   halted_q, halted_d;
    logic [count_width-1:0] count_q, count_d;

    // State register; reset abandons any outstanding fetch immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            read_addr_q   <= reset_addr;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            read_addr_q   <= read_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            count_q       <= count_d;
        end
    end

    // Next-state logic: fetch in REQ, wait for retire in ISSUE, park in HALTED.
    always_comb begin
        state_d       = state_q;
        read_addr_d   = read_addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        count_d       = count_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    read_addr_d   = next_instr_addr;
                    instr_valid_d = 1'b0;
                    count_d       = count_q + 1'b1;
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        state_d  = REQ;
                    end
                end
            end
            HALTED: begin
                instr_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_addr     = read_addr_q;
    assign imem_addr     = read_addr_q;
    assign imem_req      = (state_q == REQ);
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign halted        = halted_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: memory model with programmable ack delay,
// a PC/retire model, and a queue of expected fetch addresses.
module tb_pc_fetch_unit;

    localparam int PCW = 32;
    localparam int IW  = 32;
    localparam int CW  = 8;

    logic           clk;
    logic           rst;
    logic [PCW-1:0] nextAddr;
    logic [PCW-1:0] readAddr;
    logic           imemReq;
    logic [PCW-1:0] imemAddr;
    logic           imemAck;
    logic [IW-1:0]  imemRdata;
    logic [IW-1:0]  instr;
    logic           instrValid;
    logic           instrReady;
    logic           halt;
    logic           halted;
    logic [CW-1:0]  retiredCount;

    int             assertCount = 0;
    int             failCount   = 0;

    int             ackDelay;
    int             waitCnt;
    logic           ackForce;
    logic           incMode;
    logic [PCW-1:0] jumpAddr;

    logic [PCW-1:0] expQ[$];
    logic [PCW-1:0] expPc;
    logic [CW-1:0]  expCount;
    logic           expHalted;
    logic [IW-1:0]  curInstr;
    logic           prevValid;

    pc_fetch_unit #(
        .pc_width   (PCW),
        .instr_width(IW),
        .reset_addr ('0),
        .count_width(CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .next_instr_addr(nextAddr),
        .read_addr      (readAddr),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_ack       (imemAck),
        .imem_rdata     (imemRdata),
        .instr          (instr),
        .instr_valid    (instrValid),
        .instr_ready    (instrReady),
        .halt           (halt),
        .halted         (halted),
        .retired_count  (retiredCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction word stored at a given address in the memory model.
    function automatic logic [IW-1:0] memWord(input logic [PCW-1:0] a);
        logic [IW-1:0] w;
        w = 32'hA5A5_0000 + {16'h0, a[15:0]} + 32'd1;
        return w;
    endfunction

    // Memory model: ack after ackDelay stalled cycles, data valid with ack.
    assign imemAck   = ackForce | (imemReq && (waitCnt >= ackDelay));
    assign imemRdata = memWord(imemAddr);
    assign nextAddr  = incMode ? (readAddr + 32'd1) : jumpAddr;

    // Count consecutive stalled request cycles for the memory model.
    always @(posedge clk) begin
        if (rst) waitCnt <= 0;
        else     waitCnt <= (imemReq && !imemAck) ? waitCnt + 1 : 0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (instrValid) break;
            tick(1);
        end
        checkOutput("waitValid", {31'd0, instrValid}, 32'd1);
    endtask

    // Scoreboard/monitor: tracks the expected PC, count and halt, pops an
    // expected fetch address per new instruction, and pushes the next one
    // whenever a retire is about to happen.
    always @(negedge clk) begin
        logic [PCW-1:0] e;
        logic [PCW-1:0] nxt;
        if (rst) begin
            expQ      = {};
            expQ.push_back('0);
            expPc     = '0;
            expCount  = '0;
            expHalted = 1'b0;
            prevValid = 1'b0;
            curInstr  = '0;
        end else begin
            checkOutput("rdAddr", readAddr, expPc);
            checkOutput("count", {24'd0, retiredCount}, {24'd0, expCount});
            checkOutput("halted", {31'd0, halted}, {31'd0, expHalted});
            if (imemReq) checkOutput("imemAddr", imemAddr, expPc);
            if (instrValid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("sbEmpty", 32'd0, 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("fetchAddr", readAddr, e);
                    curInstr = memWord(e);
                end
            end
            if (instrValid) checkOutput("instr", instr, curInstr);
            if (instrValid && instrReady) begin
                nxt      = incMode ? (expPc + 32'd1) : jumpAddr;
                expPc    = nxt;
                expCount = expCount + 1'b1;
                if (halt) expHalted = 1'b1;
                else      expQ.push_back(nxt);
            end
            prevValid = instrValid;
        end
    end

    task automatic applyStimulus();
        int reqCnt;

        // Reset state and first fetch with zero-wait memory.
        rst = 1'b1; ackDelay = 0; ackForce = 1'b0; incMode = 1'b1;
        jumpAddr = '0; instrReady = 1'b1; halt = 1'b0;
        tick(3);
        checkOutput("rstAddr", readAddr, 32'd0);
        checkOutput("rstReq", {31'd0, imemReq}, 32'd0);
        checkOutput("rstInstr", instr, 32'd0);
        checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
        checkOutput("rstHalted", {31'd0, halted}, 32'd0);
        checkOutput("rstCount", {24'd0, retiredCount}, 32'd0);
        rst = 1'b0;
        tick(1);
        checkOutput("idleToReq", {31'd0, imemReq}, 32'd1);
        checkOutput("noEarlyValid", {31'd0, instrValid}, 32'd0);
        tick(1);
        checkOutput("firstValid", {31'd0, instrValid}, 32'd1);
        checkOutput("firstInstr", instr, 32'hA5A5_0001);
        tick(5);
        checkOutput("threeRetired", {24'd0, retiredCount}, 32'd3);
        checkOutput("pcAfter3", readAddr, 32'd3);

        // Memory stall of four cycles.
        ackDelay = 4;
        reqCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!imemReq) break;
            reqCnt++;
            checkOutput("stallAddr", imemAddr, 32'd3);
        end
        checkOutput("stallReqCycles", reqCnt, 32'd5);
        checkOutput("validAfterAck", {31'd0, instrValid}, 32'd1);
        @(posedge clk); #1;
        ackDelay = 0;

        // Downstream stall then a jump.
        instrReady = 1'b0;
        waitValid(20);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("holdInstr", instr, memWord(32'd4));
            checkOutput("holdAddr", readAddr, 32'd4);
            checkOutput("holdCount", {24'd0, retiredCount}, 32'd4);
        end
        incMode = 1'b0; jumpAddr = 32'h40; instrReady = 1'b1;
        tick(1);
        checkOutput("jumpAddr", readAddr, 32'h40);
        incMode = 1'b1;

        // Halt: pulse during REQ is ignored, then halt on retire at 0x10.
        instrReady = 1'b0;
        waitValid(20);
        incMode = 1'b0; jumpAddr = 32'h10; instrReady = 1'b1;
        tick(1);
        incMode = 1'b1; instrReady = 1'b0; halt = 1'b1;
        tick(1);
        halt = 1'b0;
        checkOutput("haltInReq", {31'd0, halted}, 32'd0);
        checkOutput("validAt10", {31'd0, instrValid}, 32'd1);
        halt = 1'b1; instrReady = 1'b1;
        tick(1);
        checkOutput("haltedSet", {31'd0, halted}, 32'd1);
        checkOutput("haltAddr", readAddr, 32'h11);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("haltNoReq", {31'd0, imemReq}, 32'd0);
            checkOutput("haltNoValid", {31'd0, instrValid}, 32'd0);
        end
        halt = 1'b0;

        // Reset mid-request with a stale ack afterwards.
        instrReady = 1'b0; ackDelay = 3;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        checkOutput("midReq", {31'd0, imemReq}, 32'd1);
        rst = 1'b1; ackForce = 1'b1;
        #1;
        checkOutput("asyncReq", {31'd0, imemReq}, 32'd0);
        checkOutput("asyncAddr", readAddr, 32'd0);
        checkOutput("asyncCount", {24'd0, retiredCount}, 32'd0);
        checkOutput("asyncHalted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        checkOutput("staleAck", {31'd0, instrValid}, 32'd0);
        checkOutput("freshAddr", imemAddr, 32'd0);
        ackForce = 1'b0; ackDelay = 0;
        waitValid(20);

        // PC wrap from all-ones and retired counter wrap.
        incMode = 1'b0; jumpAddr = 32'hFFFF_FFFF; instrReady = 1'b1;
        tick(1);
        incMode = 1'b1; instrReady = 1'b0;
        waitValid(20);
        checkOutput("allOnesAddr", readAddr, 32'hFFFF_FFFF);
        instrReady = 1'b1;
        tick(1);
        checkOutput("wrapAddr", readAddr, 32'd0);
        for (int i = 0; i < 1000; i++) begin
            if (retiredCount == 8'hFF) break;
            tick(1);
        end
        checkOutput("countFull", {24'd0, retiredCount}, 32'h0000_00FF);
        tick(2);
        checkOutput("countWrap", {24'd0, retiredCount}, 32'd0);
        instrReady = 1'b0;
        tick(4);
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
